// File: rtl/simple_logic_pkg.sv
// Shared mode encoding and the per-group reduction used by stage 1 of
// simple_logic_pipe.
package simple_logic_pkg;

    localparam logic MODE_POS = 1'b0;
    localparam logic MODE_SOP = 1'b1;

    localparam int MAX_GROUPS  = 32;
    localparam int MAX_GROUP_W = 32;
    localparam int MAX_BITS    = MAX_GROUPS * MAX_GROUP_W;

    // OR (POS) or AND (SOP) of each group; bits beyond groups stay 0.
    function automatic logic [MAX_GROUPS-1:0] group_reduce(
        input logic [MAX_BITS-1:0] data,
        input logic                mode,
        input int                  groups,
        input int                  group_w
    );
        logic [MAX_GROUPS-1:0] grp;
        logic                  acc;
        grp = '0;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            acc = (mode == MODE_SOP);
            for (int b = 0; b < MAX_GROUP_W; b++) begin
                if (g < groups && b < group_w) begin
                    if (mode == MODE_SOP)
                        acc = acc & data[g*group_w + b];
                    else
                        acc = acc | data[g*group_w + b];
                end
            end
            if (g < groups)
                grp[g] = acc;
        end
        return grp;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// Generic valid/ready register slice; loads when empty or when its
// current content is taken downstream in the same cycle.
module logic_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_ready) begin
            vld_q <= in_valid;
            if (in_valid)
                data_q <= in_data;
        end
    end

endmodule

// File: rtl/simple_logic_pipe.sv
// Two-stage AND-of-ORs / OR-of-ANDs reducer with valid/ready flow control
// and a saturating count of delivered 1-results.
module simple_logic_pipe
    import simple_logic_pkg::*;
#(
    parameter int GROUPS  = 2,
    parameter int GROUP_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [GROUPS*GROUP_W-1:0] in_data,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_data,
    output logic [CNT_W-1:0]          hit_cnt,
    input  logic                      cnt_clr
);

    localparam int S1_W = GROUPS + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [GROUPS-1:0] grp_p0;
    logic [S1_W-1:0]   s1_data_p1;
    logic [GROUPS-1:0] grp_p1;
    logic              mode_p1;
    logic              vld_p1;
    logic              rdy_p1;
    logic              red_p1;
    logic              rdy_p2;
    logic              vld_p2;
    logic              data_p2;

    // Stage 0 -> 1: per-group reduction registered with its mode
    assign grp_p0 = GROUPS'(group_reduce(MAX_BITS'(in_data), in_mode, GROUPS, GROUP_W));

    logic_pipe_stage #(.WIDTH(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (rdy_p1),
        .in_data   ({in_mode, grp_p0}),
        .out_valid (vld_p1),
        .out_ready (rdy_p2),
        .out_data  (s1_data_p1)
    );

    assign grp_p1  = s1_data_p1[GROUPS-1:0];
    assign mode_p1 = s1_data_p1[GROUPS];

    // Stage 1 -> 2: final reduction across groups
    assign red_p1 = (mode_p1 == MODE_SOP) ? |grp_p1 : &grp_p1;

    logic_pipe_stage #(.WIDTH(1)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_ready  (rdy_p2),
        .in_data   (red_p1),
        .out_valid (vld_p2),
        .out_ready (out_ready),
        .out_data  (data_p2)
    );

    // Ready is suppressed while reset is held so nothing is offered to a stage being cleared
    assign in_ready  = rdy_p1 && !rst;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;

    // Output side: count delivered 1-results; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hit_cnt <= '0;
        else if (cnt_clr)
            hit_cnt <= '0;
        else if (vld_p2 && out_ready && data_p2 && hit_cnt != CNT_MAX)
            hit_cnt <= hit_cnt + 1'b1;
    end

endmodule

// File: tb/tb_simple_logic_pipe.sv
// Randomized and directed bench for simple_logic_pipe against a queue-based
// transaction model.
module tb_simple_logic_pipe;

    localparam int GROUPS  = 2;
    localparam int GROUP_W = 2;
    localparam int CNT_W   = 2;
    localparam int DW      = GROUPS * GROUP_W;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_data;
    logic [CNT_W-1:0] hit_cnt;
    logic             cnt_clr;

    simple_logic_pipe #(.GROUPS(GROUPS), .GROUP_W(GROUP_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .hit_cnt   (hit_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic d;
        int   st;
    } item_t;

    item_t q[$];
    int    mcnt;
    int    n_chk;
    int    n_err;
    int    n_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Mode 0: every group has a set bit. Mode 1: some group is all ones.
    function automatic logic ref_result(input logic [DW-1:0] d, input logic m);
        int nz = 0;
        int full = 0;
        logic [GROUP_W-1:0] gv;
        for (int g = 0; g < GROUPS; g++) begin
            gv = d[g*GROUP_W +: GROUP_W];
            if (gv != 0) nz++;
            if (gv == {GROUP_W{1'b1}}) full++;
        end
        return m ? (full > 0) : (nz == GROUPS);
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic m,
                         input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        cnt_clr   = clr;
    endtask

    task automatic cyc();
        logic s1occ, s2occ, s2adv, e_irdy, oacc;
        #1;
        s2occ  = (q.size() > 0) && (q[0].st == 2);
        s1occ  = (q.size() > 0) && (q[q.size()-1].st == 1);
        s2adv  = s1occ && (!s2occ || out_ready);
        e_irdy = !s1occ || s2adv;
        check("in_ready", 32'(in_ready), 32'(e_irdy));
        check("out_valid", 32'(out_valid), 32'(s2occ));
        if (s2occ) check("out_data", 32'(out_data), 32'(q[0].d));
        check("hit_cnt", 32'(hit_cnt), mcnt);
        if (in_valid && in_ready) n_acc++;
        @(posedge clk);
        oacc = s2occ && out_ready;
        if (cnt_clr) mcnt = 0;
        else if (oacc && q[0].d && mcnt < CMAX) mcnt++;
        if (oacc) void'(q.pop_front());
        if (s2adv) q[q.size()-1].st = 2;
        if (in_valid && e_irdy) q.push_back('{d: ref_result(in_data, in_mode), st: 1});
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        mcnt  = 0;
        rst   = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_hit_cnt", 32'(hit_cnt), 0);
        rst = 1'b0;

        // basic POS hit, 2-cycle latency
        drive(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0); cyc();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        check("t1_hit", 32'(hit_cnt), 1);

        // POS miss, SOP hit
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0); cyc();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        check("t2_hit_unchanged", 32'(hit_cnt), 1);
        drive(1'b1, 4'b1100, 1'b1, 1'b1, 1'b0); cyc();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        check("t2_sop_hit", 32'(hit_cnt), 2);

        // alternating modes, back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'($urandom), 1'(i % 2), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();

        // back-pressure: exactly two accepts, then drain
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'($urandom), 1'($urandom), 1'b0, 1'b0);
            cyc();
        end
        check("bp_accepts", n_acc, 2);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();

        // async reset with both stages full
        drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        check("pre_rst_hit", 32'(hit_cnt != 0), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_hit_cnt", 32'(hit_cnt), 0);
        check("arst_in_ready", 32'(in_ready), 0);
        q.delete();
        mcnt = 0;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0); cyc();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        check("post_rst_hit", 32'(hit_cnt), 1);

        // saturation
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1); cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        check("hit_sat", 32'(hit_cnt), CMAX);

        // clear collides with an accepted 1-result
        drive(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0); cyc();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cyc();
        check("clr_col_out_valid", 32'(out_valid), 1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1); cyc();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cyc();
        check("clr_wins", 32'(hit_cnt), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
            cyc();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/simple_logic_pipe.md
# simple_logic_pipe

Parametrised, fully pipelined two-level logic reducer that generalises the registered OR/OR/AND datapath to any number of input groups and group widths. It supports a selectable per-transaction mode (AND-of-ORs or OR-of-ANDs) and valid/ready flow control with back-pressure. It also keeps a saturating count of delivered 1-results. It sits between a producer and a consumer stream, replacing hand-instantiated gate/flop netlists of the same shape.

## Interface
- GROUPS, default 2: number of input groups; must be ≥ 2.
- GROUP_W, default 2: bits per group; must be ≥ 1.
- CNT_W, default 8: width of the hit counter.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  GROUPS*GROUP_W  operand bits; group g is in_data[g*GROUP_W +: GROUP_W].
- in_mode  input  1  0 = AND of group-ORs (POS); 1 = OR of group-ANDs (SOP).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  1  reduced result.
- hit_cnt  output  CNT_W  number of accepted results equal to 1, saturating.
- cnt_clr  input  1  synchronous clear of hit_cnt.

## Operation
- Stage 1 (S1): on input accept (in_valid && in_ready), register the per-group reduction vector grp[GROUPS-1:0], the mode and s1_valid=1.
  - Mode 0: grp[g] = OR of group g.
  - Mode 1: grp[g] = AND of group g.
- Stage 2 (S2): when S1 advances, register s2_data and s2_valid=1.
  - Mode 0: s2_data = AND of grp.
  - Mode 1: s2_data = OR of grp.
  - The mode travels with the data, so a mode change between transactions is legal every cycle.
- out_valid = s2_valid; out_data = s2_data.
- Flow control:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_adv.
  - A stage with no incoming transaction clears its valid bit when its content leaves.
- Output hold: out_data and out_valid are held stable while out_valid && !out_ready.
- Hit counter:
  - Increments on out_valid && out_ready && out_data.
  - Holds at 2^CNT_W-1 once reached (saturates).
  - cnt_clr forces it to 0. When cnt_clr and an increment occur in the same cycle, cnt_clr wins and the result is 0.

## Timing
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, hit_cnt=0. in_ready=0 while rst is asserted and 1 in the first cycle after release.
- Reset mid-operation clears all valids immediately; in-flight transactions are discarded and are not counted.
- Latency: 2 cycles from input accept to out_valid, with no back-pressure.
- Throughput: 1 result per cycle while out_ready=1.
- Back-pressure:
  - With out_ready=0, the block accepts at most 2 transactions (S1 and S2 full); in_ready then drops to 0 in the same cycle that S1 becomes blocked.
  - in_ready depends combinationally on out_ready (no registered ready). This is accepted; there is no combinational path from in_* to out_*.
- Simultaneous events:
  - Output accept and S1→S2 advance in the same cycle are both performed.
  - A new input may be accepted in the same cycle.

## Structure
- Package simple_logic_pkg holds:
  - the mode constants MODE_POS=1'b0 and MODE_SOP=1'b1;
  - a function that computes the group-reduction vector from in_data, the mode, GROUPS and GROUP_W.
- Sub-module logic_pipe_stage: a generic valid/ready register slice with parameter WIDTH, the same clk/rst, and the same async reset of valid and data. It is instantiated twice: WIDTH=GROUPS+1 for S1 (grp plus mode) and WIDTH=1 for S2.
- The hit counter and the final reduction live in the top level.

## Test plan
- Defaults (GROUPS=2, GROUP_W=2), mode 0, in_data=4'b0101, out_ready=1 → out_valid=1 with out_data=1 exactly 2 cycles after accept; hit_cnt=1.
- Mode 0, in_data=4'b0011 → out_data=0 and hit_cnt unchanged. Mode 1, in_data=4'b1100 → out_data=1.
- Alternate the mode every cycle over 8 back-to-back inputs → 8 consecutive outputs, each matching a per-transaction reference model; no bubbles.
- Hold out_ready=0 with in_valid=1 → exactly 2 accepts, then in_ready=0 and out_data stable. Release out_ready → results drain in order and in_ready returns to 1 in the same cycle.
- CNT_W=2, drive 5 results equal to 1 → hit_cnt saturates at 3. Assert cnt_clr in the same cycle as an accepted 1-result → hit_cnt=0.
- Assert rst asynchronously (mid-clock) with both stages full → out_valid=0 and hit_cnt=0 immediately. After release, the first new input appears 2 cycles after accept and no stale results appear.
